traffic_ctrl: RTL
=================

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter MIN_GREEN, default 4, minimum cycles a green phase SHALL be held (range 1..15).
REQ-002 Parameter MAX_GREEN, default 10, cycles after which a green phase SHALL yield to a pending requester (MIN_GREEN..15).
REQ-003 Parameter YELLOW_CYCLES, default 2, length of each yellow phase (1..15).
REQ-004 Parameter WALK_CYCLES, default 3, length of the pedestrian all-red phase (1..15).
REQ-005 CLK  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 TA  input  1  vehicle present on street A.
REQ-008 TB  input  1  vehicle present on street B.
REQ-009 PED  input  1  pedestrian request, any-length pulse.
REQ-010 LA  output  2  street A light: 00 green, 01 yellow, 10 red.
REQ-011 LB  output  2  street B light, same encoding.
REQ-012 WALK  output  1  pedestrian walk lamp.
REQ-013 S  output  3  current state: AG=0, AY=1, BG=2, BY=3, WK=4.

Function
REQ-014 Outputs SHALL be Moore: decoded from S only, no input-to-output combinational path.
REQ-015 AG: LA=00, LB=10; BG: LA=10, LB=00; AY: LA=01, LB=10; BY: LA=10, LB=01; WK: LA=LB=10, WALK=1; WALK=0 in all other states.
REQ-016 A 4-bit phase timer SHALL clear to 0 on every state change and increment each cycle in a state, saturating at 15.
REQ-017 AG->AY at the edge where timer==MIN_GREEN-1 when TA=0 and (TB=1 or ped_pend=1).
REQ-018 AG->AY at the edge where timer>=MAX_GREEN-1 when TA=1 and (TB=1 or ped_pend=1); otherwise AG SHALL hold indefinitely.
REQ-019 BG SHALL mirror REQ-017/018 with TA/TB swapped, exiting to BY.
REQ-020 AY->(WK if ped_pend else BG) and BY->(WK if ped_pend else AG) at the edge where timer==YELLOW_CYCLES-1.
REQ-021 WK SHALL exit at timer==WALK_CYCLES-1 to the green of the street not served before WK (1-bit next_street register).
REQ-022 ped_pend SHALL set on any cycle PED=1 outside WK, clear on the edge entering WK; PED during WK SHALL be ignored.
REQ-023 Simultaneous TB and ped_pend at AG exit SHALL serve the pedestrian first (AY->WK->BG).

Reset
REQ-024 reset=1 SHALL immediately force S=AG, timer=0, ped_pend=0, next_street=B, hence LA=00, LB=10, WALK=0, regardless of CLK, including mid-phase.

Configuration
REQ-025 Macro TRAFFIC_CTRL_PED_EN defined: pedestrian logic per REQ-020..023 present.
REQ-026 Macro undefined: PED port kept but ignored, ped_pend constant 0, WK unreachable, WALK tied 0, street alternation unchanged.

Structure
REQ-027 Package traffic_pkg SHALL hold the state encoding typedef, light encoding constants (GREEN/YELLOW/RED) and timer width.
REQ-028 Sub-module phase_timer (4-bit saturating counter with synchronous clear, async reset) SHALL be instantiated once.

Verification
REQ-029 Reset, TA=1, TB=0, PED=0 for 30 cycles -> S=0, LA=00, LB=10 throughout.
REQ-030 Reset, TA=0, TB=1 -> AG 4 cycles, AY 2 cycles, BG entered at 6th edge after reset release, LB=00.
REQ-031 TA=TB=1 constant -> cycle AG10, AY2, BG10, BY2, period 24, repeating.
REQ-032 TRAFFIC_CTRL_PED_EN defined, TA=TB=0, 1-cycle PED at cycle 1 -> AG4, AY2, WK3 with WALK=1 and LA=LB=10, then BG.
REQ-033 reset pulse mid-AY (timer=1), asynchronous to CLK -> S=0, LA=00 before next edge; normal sequencing resumes.
REQ-034 Macro undefined, scenario of REQ-032 repeated -> PED has no effect, WALK=0, S never 4.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller.
package traffic_pkg;

  // Phase timer width; the timer saturates at its all-ones value.
  localparam int unsigned TIMER_W = 4;

  // Light encodings driven on LA / LB.
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // Controller state; the encoding is visible on the S output.
  typedef enum logic [2:0] {
    StAg = 3'd0,
    StAy = 3'd1,
    StBg = 3'd2,
    StBy = 3'd3,
    StWk = 3'd4
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase timer with synchronous clear and asynchronous active-high reset.
module phase_timer
  import traffic_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  output logic [TIMER_W-1:0] count_o
);

  // Count cycles spent in the current phase; hold at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (count_o != '1) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Two-street traffic light controller with optional pedestrian all-red phase.
// Build option: define TRAFFIC_CTRL_PED_EN to enable the pedestrian logic; otherwise
// PED is ignored, WALK stays 0 and the walk state is never entered.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned MAX_GREEN     = 10,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned WALK_CYCLES   = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       TA,
  input  logic       TB,
  input  logic       PED,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       WALK,
  output logic [2:0] S
);

  localparam logic [TIMER_W-1:0] MinLast  = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MaxLast  = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YelLast  = TIMER_W'(YELLOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WalkLast = TIMER_W'(WALK_CYCLES - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer;
  logic               ped_pend;
  logic               next_b;  // 1: street B gets the green after the walk phase

  phase_timer u_phase_timer (
    .clk_i   (CLK),
    .rst_i   (reset),
    .clr_i   (state_d != state_q),
    .count_o (timer)
  );

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StAg;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef TRAFFIC_CTRL_PED_EN
  logic ped_pend_q, ped_pend_d;
  logic next_b_q, next_b_d;

  // Pedestrian latch and street-to-serve-after-walk register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ped_pend_q <= 1'b0;
      next_b_q   <= 1'b1;
    end else begin
      ped_pend_q <= ped_pend_d;
      next_b_q   <= next_b_d;
    end
  end

  // Latch requests outside the walk phase; entering walk consumes the request.
  always_comb begin
    ped_pend_d = ped_pend_q;
    next_b_d   = next_b_q;
    if (PED && (state_q != StWk)) ped_pend_d = 1'b1;
    if ((state_d == StWk) && (state_q != StWk)) ped_pend_d = 1'b0;
    if ((state_q == StAg) && (state_d == StAy)) next_b_d = 1'b1;
    if ((state_q == StBg) && (state_d == StBy)) next_b_d = 1'b0;
  end

  assign ped_pend = ped_pend_q;
  assign next_b   = next_b_q;
`else
  logic unused_ped;
  assign unused_ped = PED;
  assign ped_pend   = 1'b0;
  assign next_b     = 1'b1;
`endif

  // Next-state logic. Green exit uses >= so a request arriving after the minimum
  // green (timer saturated or still counting) is still served.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAg: if ((TB || ped_pend) && ((!TA && timer >= MinLast) || timer >= MaxLast)) begin
        state_d = StAy;
      end
      StAy: if (timer == YelLast) begin
        state_d = ped_pend ? StWk : StBg;
      end
      StBg: if ((TA || ped_pend) && ((!TB && timer >= MinLast) || timer >= MaxLast)) begin
        state_d = StBy;
      end
      StBy: if (timer == YelLast) begin
        state_d = ped_pend ? StWk : StAg;
      end
      StWk: if (timer == WalkLast) begin
        state_d = next_b ? StBg : StAg;
      end
      default: state_d = StAg;
    endcase
  end

  // Moore output decode from the current state only.
  always_comb begin
    LA   = RED;
    LB   = RED;
    WALK = 1'b0;
    unique case (state_q)
      StAg: LA = GREEN;
      StAy: LA = YELLOW;
      StBg: LB = GREEN;
      StBy: LB = YELLOW;
      StWk: WALK = 1'b1;
      default: ;
    endcase
  end

  assign S = state_q;

endmodule
